// File: rtl/bc_control_unit.sv
// bc_control_unit: timing-and-control sequencer for the basic computer.
// Runs the T0..T6 sequence counter, latches the indirect bit and decodes the
// IR, AC/DR/E flags and current T state into register strobes, the common-bus
// select, the memory write strobe and the ALU operation code.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ir_outdata[15:0]    - instruction register (I, opcode, address/reg bits)
//   ac_outdata[15:0]    - AC, for sign/zero skip tests
//   dr_outdata[15:0]    - DR, for the ISZ zero test
//   e_outdata           - E flip-flop, for SZE
//   bus_sel[2:0]        - common-bus source select
//   ar_*/pc_*/dr_*/ac_*/ir_ld/e_clr - register strobes
//   mem_we              - write bus value to M[AR]
//   alu_code[3:0]       - ALU operation
//   halted              - set by HLT, cleared only by rst
//   sc_out[2:0]         - current T state
module bc_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_outdata,
  input  logic [15:0] ac_outdata,
  input  logic [15:0] dr_outdata,
  input  logic        e_outdata,
  output logic [2:0]  bus_sel,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ac_inc,
  output logic        ac_clr,
  output logic        ir_ld,
  output logic        e_clr,
  output logic        mem_we,
  output logic [3:0]  alu_code,
  output logic        halted,
  output logic [2:0]  sc_out
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 12;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_LDA  = 4'b0011;
  localparam logic [3:0] ALU_CMA  = 4'b1001;
  localparam logic [3:0] ALU_CME  = 4'b1010;
  localparam logic [3:0] ALU_CIR  = 4'b1011;
  localparam logic [3:0] ALU_CIL  = 4'b1100;
  localparam logic [3:0] ALU_INP  = 4'b1101;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } sc_e;

  sc_e               sc;
  sc_e               sc_next;
  logic              i_ff;
  logic              i_latch;
  logic              halt_set;
  logic              sc_clr;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] ref_bits;
  logic              ac_zero;
  logic              dr_zero;

  assign opcode   = ir_outdata[14:12];
  assign ref_bits = ir_outdata[ADDR_W-1:0];
  assign ac_zero  = (ac_outdata == WORD_W'(0));
  assign dr_zero  = (dr_outdata == WORD_W'(0));
  assign sc_out   = sc;

  // Sequence counter, indirect flag and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc     <= T0;
      i_ff   <= 1'b0;
      halted <= 1'b0;
    end else begin
      sc <= sc_next;
      if (i_latch) begin
        i_ff <= ir_outdata[15];
      end
      if (halt_set) begin
        halted <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode; everything idles during reset or halt.
  always_comb begin
    sc_next  = T0;
    sc_clr   = 1'b0;
    halt_set = 1'b0;
    i_latch  = 1'b0;
    bus_sel  = BUS_NONE;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_inc   = 1'b0;
    ac_clr   = 1'b0;
    ir_ld    = 1'b0;
    e_clr    = 1'b0;
    mem_we   = 1'b0;
    alu_code = ALU_IDLE;

    if (!rst && !halted) begin
      case (sc)
        T0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          bus_sel = BUS_MEM;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
          i_latch = 1'b1;
        end
        T3: begin
          if (opcode == OP_REG) begin
            sc_clr = 1'b1;
            if (!i_ff) begin
              // Register reference: highest set bit wins.
              if (ref_bits[11]) begin
                ac_clr = 1'b1;
              end else if (ref_bits[10]) begin
                e_clr = 1'b1;
              end else if (ref_bits[9]) begin
                alu_code = ALU_CMA;
                ac_ld    = 1'b1;
              end else if (ref_bits[8]) begin
                alu_code = ALU_CME;
              end else if (ref_bits[7]) begin
                alu_code = ALU_CIR;
                ac_ld    = 1'b1;
              end else if (ref_bits[6]) begin
                alu_code = ALU_CIL;
                ac_ld    = 1'b1;
              end else if (ref_bits[5]) begin
                ac_inc = 1'b1;
              end else if (ref_bits[4]) begin
                pc_inc = ~ac_outdata[15];
              end else if (ref_bits[3]) begin
                pc_inc = ac_outdata[15];
              end else if (ref_bits[2]) begin
                pc_inc = ac_zero;
              end else if (ref_bits[1]) begin
                pc_inc = ~e_outdata;
              end else if (ref_bits[0]) begin
                halt_set = 1'b1;
              end
            end else if (ref_bits[11]) begin
              alu_code = ALU_INP;
              ac_ld    = 1'b1;
            end
          end else if (i_ff) begin
            // Indirect: fetch the effective address.
            bus_sel = BUS_MEM;
            ar_ld   = 1'b1;
          end
        end
        T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_we  = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_we  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        T5: begin
          case (opcode)
            OP_AND: begin
              alu_code = ALU_AND;
              ac_ld    = 1'b1;
              sc_clr   = 1'b1;
            end
            OP_ADD: begin
              alu_code = ALU_ADD;
              ac_ld    = 1'b1;
              sc_clr   = 1'b1;
            end
            OP_LDA: begin
              alu_code = ALU_LDA;
              ac_ld    = 1'b1;
              sc_clr   = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_ISZ: begin
              dr_inc = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        T6: begin
          sc_clr = 1'b1;
          if (opcode == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_we  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase

      // T6 is the last legal state; anything at or above it wraps to T0.
      if (sc_clr || (sc >= T6)) begin
        sc_next = T0;
      end else begin
        sc_next = sc_e'(3'(sc) + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_bc_control_unit.sv
// Testbench for bc_control_unit: per-cycle expected output vectors are queued
// per instruction and compared at the falling edge of each cycle.
module tb_bc_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic [15:0] ac = '0;
  logic [15:0] dr = '0;
  logic        e  = 1'b0;

  logic [2:0] bus_sel;
  logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic       ac_ld, ac_inc, ac_clr, ir_ld, e_clr, mem_we;
  logic [3:0] alu_code;
  logic       halted;
  logic [2:0] sc_out;

  logic [22:0] obs;
  logic [22:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  localparam int AR_LD  = 1 << 11;
  localparam int AR_INC = 1 << 10;
  localparam int PC_LD  = 1 << 9;
  localparam int PC_INC = 1 << 8;
  localparam int DR_LD  = 1 << 7;
  localparam int DR_INC = 1 << 6;
  localparam int AC_LD  = 1 << 5;
  localparam int AC_INC = 1 << 4;
  localparam int AC_CLR = 1 << 3;
  localparam int IR_LD  = 1 << 2;
  localparam int E_CLR  = 1 << 1;
  localparam int MEM_WE = 1 << 0;

  bc_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ir_outdata (ir),
    .ac_outdata (ac),
    .dr_outdata (dr),
    .e_outdata  (e),
    .bus_sel    (bus_sel),
    .ar_ld      (ar_ld),
    .ar_inc     (ar_inc),
    .pc_ld      (pc_ld),
    .pc_inc     (pc_inc),
    .dr_ld      (dr_ld),
    .dr_inc     (dr_inc),
    .ac_ld      (ac_ld),
    .ac_inc     (ac_inc),
    .ac_clr     (ac_clr),
    .ir_ld      (ir_ld),
    .e_clr      (e_clr),
    .mem_we     (mem_we),
    .alu_code   (alu_code),
    .halted     (halted),
    .sc_out     (sc_out)
  );

  always #5 clk = ~clk;

  assign obs = {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
                ac_ld, ac_inc, ac_clr, ir_ld, e_clr, mem_we,
                alu_code, halted, sc_out};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] ev(input int bus, input int st, input int alu,
                                     input int h, input int sc);
    return {3'(bus), 12'(st), 4'(alu), 1'(h), 3'(sc)};
  endfunction

  task automatic push_fetch();
    sb.push_back(ev(2, AR_LD, 0, 0, 0));
    sb.push_back(ev(7, IR_LD | PC_INC, 0, 0, 1));
    sb.push_back(ev(5, AR_LD, 0, 0, 2));
  endtask

  // Reset while idle, then abort an ADD in T4 and restart it cleanly.
  task automatic test_reset();
    logic [22:0] exp_v;
    int step = 0;
    rst = 1'b1;
    ir  = 16'h1005;
    @(posedge clk);
    @(negedge clk);
    sb.push_back(ev(0, 0, 0, 0, 0));
    exp_v = sb.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    push_fetch();
    sb.push_back(ev(0, 0, 0, 0, 3));
    sb.push_back(ev(7, DR_LD, 0, 0, 4));
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_pre step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      if (sb.size() != 0) @(posedge clk);
    end
    // Mid-T4: asynchronous reset must clear everything immediately.
    #1 rst = 1'b1;
    #1;
    sb.push_back(ev(0, 0, 0, 0, 0));
    exp_v = sb.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", obs, exp_v);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    push_fetch();
    sb.push_back(ev(0, 0, 0, 0, 3));
    sb.push_back(ev(7, DR_LD, 0, 0, 4));
    sb.push_back(ev(0, AC_LD, 4'b0010, 0, 5));
    step = 0;
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_restart step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
  endtask

  task automatic test_add_direct();
    logic [22:0] exp_v;
    int step = 0;
    #1 ir = 16'h1005;
    push_fetch();
    sb.push_back(ev(0, 0, 0, 0, 3));
    sb.push_back(ev(7, DR_LD, 0, 0, 4));
    sb.push_back(ev(0, AC_LD, 4'b0010, 0, 5));
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL add_direct step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
  endtask

  task automatic test_lda_indirect();
    logic [22:0] exp_v;
    int step = 0;
    #1 ir = 16'hA010;
    push_fetch();
    sb.push_back(ev(7, AR_LD, 0, 0, 3));
    sb.push_back(ev(7, DR_LD, 0, 0, 4));
    sb.push_back(ev(0, AC_LD, 4'b0011, 0, 5));
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lda_indirect step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
  endtask

  task automatic test_isz();
    logic [22:0] exp_v;
    int step = 0;
    for (int k = 0; k < 2; k++) begin
      #1 ir = 16'h6010;
      dr = (k == 0) ? 16'h0000 : 16'h0001;
      push_fetch();
      sb.push_back(ev(0, 0, 0, 0, 3));
      sb.push_back(ev(7, DR_LD, 0, 0, 4));
      sb.push_back(ev(0, DR_INC, 0, 0, 5));
      sb.push_back(ev(3, (k == 0) ? (MEM_WE | PC_INC) : MEM_WE, 0, 0, 6));
      while (sb.size() != 0) begin
        exp_v = sb.pop_front();
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL isz dr=%h step %0d: got %h expected %h", dr, step, obs, exp_v);
        end
        step++;
        @(posedge clk);
      end
    end
    dr = 16'h0000;
  endtask

  task automatic test_mem_ref();
    logic [22:0] exp_v;
    int step = 0;
    logic [15:0] c_ir [5] = '{16'h3000, 16'h4123, 16'h5000, 16'h0000, 16'hB000};
    for (int k = 0; k < 5; k++) begin
      #1 ir = c_ir[k];
      push_fetch();
      sb.push_back(ev(c_ir[k][15] ? 7 : 0, c_ir[k][15] ? AR_LD : 0, 0, 0, 3));
      case (k)
        0, 4: sb.push_back(ev(4, MEM_WE, 0, 0, 4));
        1: sb.push_back(ev(1, PC_LD, 0, 0, 4));
        2: begin
          sb.push_back(ev(2, MEM_WE | AR_INC, 0, 0, 4));
          sb.push_back(ev(1, PC_LD, 0, 0, 5));
        end
        default: begin
          sb.push_back(ev(7, DR_LD, 0, 0, 4));
          sb.push_back(ev(0, AC_LD, 4'b0001, 0, 5));
        end
      endcase
      while (sb.size() != 0) begin
        exp_v = sb.pop_front();
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL mem_ref ir=%h step %0d: got %h expected %h", ir, step, obs, exp_v);
        end
        step++;
        @(posedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp_v;
    int step = 0;
    #1 ir = 16'h7040;
    for (int k = 0; k < 2; k++) begin
      push_fetch();
      sb.push_back(ev(0, AC_LD, 4'b1100, 0, 3));
    end
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL cil_b2b step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
  endtask

  task automatic test_reg_ref();
    logic [22:0] exp_v;
    int step = 0;
    logic [15:0] c_ir [16] = '{16'h7010, 16'h7010, 16'h7C00, 16'h7008, 16'h7004, 16'h7004,
                               16'h7002, 16'h7002, 16'h7100, 16'h7200, 16'h7080, 16'h7020,
                               16'h7400, 16'h7000, 16'hF800, 16'h7003};
    logic [15:0] c_ac [16] = '{16'h8000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0005,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        c_e  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int          c_st [16] = '{0, PC_INC, AC_CLR, PC_INC, PC_INC, 0, PC_INC, 0,
                               0, AC_LD, AC_LD, AC_INC, E_CLR, 0, AC_LD, PC_INC};
    int          c_alu[16] = '{0, 0, 0, 0, 0, 0, 0, 0,
                               4'b1010, 4'b1001, 4'b1011, 0, 0, 0, 4'b1101, 0};
    for (int k = 0; k < 16; k++) begin
      #1 ir = c_ir[k];
      ac = c_ac[k];
      e  = c_e[k];
      push_fetch();
      sb.push_back(ev(0, c_st[k], c_alu[k], 0, 3));
      while (sb.size() != 0) begin
        exp_v = sb.pop_front();
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL reg_ref ir=%h step %0d: got %h expected %h", ir, step, obs, exp_v);
        end
        step++;
        @(posedge clk);
      end
    end
    ac = 16'h0000;
    e  = 1'b0;
  endtask

  task automatic test_halt();
    logic [22:0] exp_v;
    int step = 0;
    #1 ir = 16'h7001;
    push_fetch();
    sb.push_back(ev(0, 0, 0, 0, 3));
    for (int k = 0; k < 20; k++) sb.push_back(ev(0, 0, 0, 1, 0));
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL halt step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
    #1 rst = 1'b1;
    ir = 16'h0000;
    sb.push_back(ev(0, 0, 0, 0, 0));
    @(negedge clk);
    exp_v = sb.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL halt_rst: got %h expected %h", obs, exp_v);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    push_fetch();
    while (sb.size() != 0) begin
      exp_v = sb.pop_front();
      @(negedge clk);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL halt_restart step %0d: got %h expected %h", step, obs, exp_v);
      end
      step++;
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_direct();
    test_lda_indirect();
    test_isz();
    test_mem_ref();
    test_back_to_back();
    test_reg_ref();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bc_control_unit.md
# bc_control_unit

Timing-and-control sequencer for the basic computer. It runs a 3-bit sequence counter (T0–T6) and latches the indirect bit. From the instruction register, the AC/DR/E values and the current state, it generates every register load/increment/clear strobe, the common-bus select, the memory write strobe, and the 4-bit `alu_code` that drives `alu_unit`. It sits between the IR/flag outputs of the register file and the control inputs of the registers, memory and ALU.

## Interface
- No parameters; word width is 16 bits and address width is 12 bits, both fixed.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ir_outdata` in 16: instruction register contents. Bit 15 is I, bits 14:12 are the opcode, bits 11:0 are the address or register-reference bits.
- `ac_outdata` in 16: AC contents; used for the sign and zero tests.
- `dr_outdata` in 16: DR contents; used for the ISZ zero test.
- `e_outdata` in 1: E flip-flop; used for SZE.
- `bus_sel` out 3: common-bus source. 0 = none, 1 = AR, 2 = PC, 3 = DR, 4 = AC, 5 = IR, 7 = MEM.
- `ar_ld`, `ar_inc` out 1 each: AR load from bus / increment.
- `pc_ld`, `pc_inc` out 1 each: PC load from bus / increment.
- `dr_ld`, `dr_inc` out 1 each: DR load from bus / increment.
- `ac_ld`, `ac_inc`, `ac_clr` out 1 each: AC load from ALU output / increment / clear.
- `ir_ld` out 1: IR load from bus.
- `e_clr` out 1: clear E.
- `mem_we` out 1: memory write of the bus value at M[AR].
- `alu_code` out 4: ALU operation. 0000 = idle, 0001 = AND, 0010 = ADD, 0011 = transfer DR, 1001 = CMA, 1010 = CME, 1011 = CIR, 1100 = CIL, 1101 = INP.
- `halted` out 1: high after HLT executes.
- `sc_out` out 3: current T state, for debug.

## Operation
- State is SC (0–6), the latched indirect flag `i_ff`, and `halted`.
- All outputs are combinational decodes of SC, `i_ff`, `ir_outdata` and the flags.
- Every strobe, `bus_sel` and `alu_code` is 0 in any state not listed below.
- Fetch:
  - T0: `bus_sel`=PC, `ar_ld`.
  - T1: `bus_sel`=MEM, `ir_ld`, `pc_inc`.
  - T2: `bus_sel`=IR, `ar_ld` (loads IR[11:0]); `i_ff`←IR[15] at the end of T2.
- Decode at T3, by opcode D = IR[14:12]:
  - D≠7 and I=1: `bus_sel`=MEM, `ar_ld` (indirect).
  - D≠7 and I=0: no operation.
  - D=7: register-reference or I/O execute, then SC←0.
- Memory reference, D = 0–6:
  - AND (0), ADD (1), LDA (2): T4 `bus_sel`=MEM, `dr_ld`; T5 `alu_code`=0001/0010/0011, `ac_ld`, SC←0.
  - STA (3): T4 `bus_sel`=AC, `mem_we`, SC←0.
  - BUN (4): T4 `bus_sel`=AR, `pc_ld`, SC←0.
  - BSA (5): T4 `bus_sel`=PC, `mem_we`, `ar_inc`; T5 `bus_sel`=AR, `pc_ld`, SC←0.
  - ISZ (6): T4 `bus_sel`=MEM, `dr_ld`; T5 `dr_inc`; T6 `bus_sel`=DR, `mem_we`, `pc_inc` if `dr_outdata`==0, SC←0.
- Register reference (D=7, I=0) at T3. Only the highest set bit of IR[11:0] executes; IR[11:0]==0 is a NOP.
  - bit 11 CLA: `ac_clr`.
  - bit 10 CLE: `e_clr`.
  - bit 9 CMA: `alu_code` 1001, `ac_ld`.
  - bit 8 CME: `alu_code` 1010.
  - bit 7 CIR: `alu_code` 1011, `ac_ld`.
  - bit 6 CIL: `alu_code` 1100, `ac_ld`.
  - bit 5 INC: `ac_inc`.
  - bit 4 SPA: `pc_inc` if AC[15]==0.
  - bit 3 SNA: `pc_inc` if AC[15]==1.
  - bit 2 SZA: `pc_inc` if AC==0.
  - bit 1 SZE: `pc_inc` if E==0.
  - bit 0 HLT: `halted`←1.
- I/O (D=7, I=1) at T3:
  - IR bit 11 (INP): `alu_code` 1101, `ac_ld`.
  - Any other pattern is a NOP.
- `alu_unit` reacts only to changes of `alu_code`. Because `alu_code` returns to 0000 in every state between ALU operations, back-to-back identical operations (e.g. CIL, CIL) each produce a fresh change.

## Timing
- Reset (asynchronous, immediate): SC=0, `i_ff`=0, `halted`=0. While `rst` is high, every output is forced to 0 (including `bus_sel` and `alu_code`), so no strobe fires during reset. Reset mid-instruction abandons it; execution restarts at T0 on the first rising edge after `rst` falls.
- SC increments by 1 per clock unless the current state asserts SC←0. SC never exceeds 6; a stray value above 6 returns to 0 on the next edge.
- Instruction latency in clocks:
  - Register reference and I/O: 4.
  - STA, BUN: 5.
  - AND, ADD, LDA, BSA: 6.
  - ISZ: 7.
- Strobes assert for exactly one cycle. The destination register captures at the rising edge that ends the state.
- `halted`:
  - Set at the end of T3 of HLT.
  - Once set, SC is frozen at 0 and all outputs are 0.
  - Only `rst` clears it.
- Skip conditions are sampled combinationally during T3 or T6, from register values as they stand at that edge.

## Test plan
- Reset with `rst`=1 mid-T4 of an ADD: all outputs go to 0 immediately. After release, `sc_out`=0 and the first cycle drives `bus_sel`=2 with `ar_ld`=1.
- ADD direct, IR=0x1005: T0–T2 fetch strobes in order; T4 `bus_sel`=7 with `dr_ld`; T5 `alu_code`=0010 with `ac_ld`; next cycle `sc_out`=0 and `alu_code`=0000.
- LDA indirect, IR=0xA010: T3 `bus_sel`=7 with `ar_ld`; T5 `alu_code`=0011; total 6 cycles.
- ISZ with `dr_outdata`=0x0000 at T6: `mem_we`=1, `bus_sel`=3, `pc_inc`=1. Repeat with DR=0x0001: `pc_inc`=0.
- Register references:
  - IR=0x7040 (CIL) twice back-to-back: `alu_code` sequence 1100, 0000×3, 1100.
  - IR=0x7010 (SPA) with AC=0x8000: no `pc_inc`.
  - IR=0x7C00: only `ac_clr` (CLA has priority).
- HLT, IR=0x7001: `halted`=1 after T3; SC stays 0 for 20 clocks with all strobes 0; `rst` pulse clears `halted`.
